// File: rtl/pbus_slot_sched_if.sv
// rtl/pbus_slot_sched_if.sv - P bus slot scheduler requester/pad bundle
//
// Groups the requester handshakes, the P bus drive/readback and the strobes
// of pbus_slot_sched.
//   slave  : seen from the scheduler (requests in, grants/bus/strobes out)
//   master : seen from the fetch units / pad logic driving the scheduler
// Optional macro PBUS_STALL_CNT_EN adds stall_cnt (out) and stall_clr (in).
interface pbus_slot_sched_if;
   logic        sync;
   logic        spr_req;
   logic        l0_req;
   logic        attr_req;
   logic        fix_req;
   logic        fpal_req;
   logic [23:0] spr_addr;
   logic [15:0] l0_addr;
   logic [7:0]  spr_pal;
   logic [7:0]  spr_xpos;
   logic [23:0] fix_addr;
   logic [3:0]  fix_pal;
   logic        spr_gnt;
   logic        l0_gnt;
   logic        attr_gnt;
   logic        fix_gnt;
   logic        fpal_gnt;
   logic [23:0] pbus_in;
   logic [23:0] pbus_out;
   logic        pbus_oe_u;
   logic        pbus_oe_l;
   logic [4:0]  slot;
   logic        pck1;
   logic        pck2;
   logic        load;
   logic        nvcs;
   logic [7:0]  l0_data;
   logic        l0_valid;
`ifdef PBUS_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic        stall_clr;

   modport slave (
      input  sync, spr_req, l0_req, attr_req, fix_req, fpal_req,
      input  spr_addr, l0_addr, spr_pal, spr_xpos, fix_addr, fix_pal,
      input  pbus_in, stall_clr,
      output spr_gnt, l0_gnt, attr_gnt, fix_gnt, fpal_gnt,
      output pbus_out, pbus_oe_u, pbus_oe_l, slot,
      output pck1, pck2, load, nvcs, l0_data, l0_valid, stall_cnt
   );

   modport master (
      output sync, spr_req, l0_req, attr_req, fix_req, fpal_req,
      output spr_addr, l0_addr, spr_pal, spr_xpos, fix_addr, fix_pal,
      output pbus_in, stall_clr,
      input  spr_gnt, l0_gnt, attr_gnt, fix_gnt, fpal_gnt,
      input  pbus_out, pbus_oe_u, pbus_oe_l, slot,
      input  pck1, pck2, load, nvcs, l0_data, l0_valid, stall_cnt
   );
`else
   modport slave (
      input  sync, spr_req, l0_req, attr_req, fix_req, fpal_req,
      input  spr_addr, l0_addr, spr_pal, spr_xpos, fix_addr, fix_pal,
      input  pbus_in,
      output spr_gnt, l0_gnt, attr_gnt, fix_gnt, fpal_gnt,
      output pbus_out, pbus_oe_u, pbus_oe_l, slot,
      output pck1, pck2, load, nvcs, l0_data, l0_valid
   );

   modport master (
      output sync, spr_req, l0_req, attr_req, fix_req, fpal_req,
      output spr_addr, l0_addr, spr_pal, spr_xpos, fix_addr, fix_pal,
      output pbus_in,
      input  spr_gnt, l0_gnt, attr_gnt, fix_gnt, fpal_gnt,
      input  pbus_out, pbus_oe_u, pbus_oe_l, slot,
      input  pck1, pck2, load, nvcs, l0_data, l0_valid
   );
`endif
endinterface

// File: rtl/pbus_slot_sched.sv
// rtl/pbus_slot_sched.sv - 32-slot P bus time-slot scheduler for the video section
//
// Ports:
//   clk_24m : master clock, all state on its rising edge
//   nreset  : asynchronous active-low reset, released synchronously upstream
//   bus     : pbus_slot_sched_if.slave - sync, five req/data/gnt requesters,
//             P bus out/OE/readback, slot, PCK1/PCK2/LOAD, nVCS, L0 capture
// Frame windows: SPR 0-2, L0 3-12, ATTR 13-15, FIX 16-18, IDLE 19-28, FPAL 29-31.
// Optional macro PBUS_STALL_CNT_EN: saturating 16-bit stall counter with
// synchronous clear (bus.stall_cnt / bus.stall_clr).
module pbus_slot_sched #(
   parameter logic [23:0] IDLE_VAL  = 24'hFF0000,
   parameter logic [23:0] EMPTY_VAL = 24'h000000
) (
   input  logic               clk_24m,
   input  logic               nreset,
   pbus_slot_sched_if.slave   bus
);

   typedef enum logic [2:0] {
      W_SPR,
      W_L0,
      W_ATTR,
      W_FIX,
      W_IDLE,
      W_FPAL
   } win_t;

   function automatic win_t win_of(input logic [4:0] s);
      if (s < 5'd3)       return W_SPR;
      else if (s < 5'd13) return W_L0;
      else if (s < 5'd16) return W_ATTR;
      else if (s < 5'd19) return W_FIX;
      else if (s < 5'd29) return W_IDLE;
      else                return W_FPAL;
   endfunction

   function automatic logic is_start(input logic [4:0] s);
      case (s)
         5'd0, 5'd3, 5'd13, 5'd16, 5'd19, 5'd29: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   logic [4:0]  slot_q;
   logic [23:0] pbus_out_q;
   logic        oe_u_q;
   logic        oe_l_q;
   logic        spr_gnt_q;
   logic        l0_gnt_q;
   logic        attr_gnt_q;
   logic        fix_gnt_q;
   logic        fpal_gnt_q;
   logic        pck1_q;
   logic        pck2_q;
   logic        load_q;
   logic        nvcs_q;
   logic [7:0]  l0_data_q;
   logic        l0_valid_q;
   // Set for the duration of a granted L0 window; cleared on any other slot
   // so a SYNC abort never leads to a capture.
   logic        l0_live_q;

   logic [4:0]  next_slot;
   logic        entering;
   win_t        next_win;
   logic        win_start;
   logic        l0_live_next;
   logic        capture;

   // Only the low byte of the readback carries L0 data.
   logic        unused_pbus_hi;
   assign unused_pbus_hi = ^bus.pbus_in[23:8];

   always_comb begin
      next_slot    = bus.sync ? 5'd0 : slot_q + 5'd1;
      // Holding SYNC at slot 0 is not a new entry: no new grants, outputs hold.
      entering     = (next_slot != slot_q);
      next_win     = win_of(next_slot);
      win_start    = is_start(next_slot);
      l0_live_next = 1'b0;
      if (next_win == W_L0)
         l0_live_next = win_start ? bus.l0_req : l0_live_q;
      // Normal exit of slot 12 only; a SYNC at slot 12 goes to 0 and skips it.
      capture      = (slot_q == 5'd12) && (next_slot == 5'd13) && l0_live_q;
   end

   always_ff @(posedge clk_24m or negedge nreset) begin
      if (!nreset) begin
         slot_q     <= 5'd0;
         pbus_out_q <= 24'h000000;
         oe_u_q     <= 1'b0;
         oe_l_q     <= 1'b0;
         spr_gnt_q  <= 1'b0;
         l0_gnt_q   <= 1'b0;
         attr_gnt_q <= 1'b0;
         fix_gnt_q  <= 1'b0;
         fpal_gnt_q <= 1'b0;
         pck1_q     <= 1'b0;
         pck2_q     <= 1'b0;
         load_q     <= 1'b0;
         nvcs_q     <= 1'b1;
         l0_data_q  <= 8'h00;
         l0_valid_q <= 1'b0;
         l0_live_q  <= 1'b0;
      end else begin
         spr_gnt_q  <= 1'b0;
         l0_gnt_q   <= 1'b0;
         attr_gnt_q <= 1'b0;
         fix_gnt_q  <= 1'b0;
         fpal_gnt_q <= 1'b0;
         l0_valid_q <= 1'b0;
         if (entering) begin
            slot_q    <= next_slot;
            l0_live_q <= l0_live_next;

            oe_u_q <= (next_win != W_L0);
            oe_l_q <= (next_win != W_L0) || l0_live_next;
            nvcs_q <= !((next_win == W_L0) && l0_live_next);

            pck1_q <= (next_slot <= 5'd1);
            pck2_q <= (next_slot == 5'd16) || (next_slot == 5'd17);
            load_q <= ((next_slot >= 5'd13) && (next_slot <= 5'd16)) ||
                      (next_slot >= 5'd29) || (next_slot == 5'd0);

            // The drive value is fixed for a whole window, so it is only
            // loaded on the window's first slot and held afterwards.
            if (win_start) begin
               case (next_win)
                  W_SPR: begin
                     spr_gnt_q  <= bus.spr_req;
                     pbus_out_q <= bus.spr_req ? bus.spr_addr : EMPTY_VAL;
                  end
                  W_L0: begin
                     l0_gnt_q   <= bus.l0_req;
                     pbus_out_q <= bus.l0_req ? {8'h00, bus.l0_addr} : 24'h000000;
                  end
                  W_ATTR: begin
                     attr_gnt_q <= bus.attr_req;
                     pbus_out_q <= bus.attr_req ? {bus.spr_pal, bus.spr_xpos, 8'h00}
                                                : EMPTY_VAL;
                  end
                  W_FIX: begin
                     fix_gnt_q  <= bus.fix_req;
                     pbus_out_q <= bus.fix_req ? bus.fix_addr : EMPTY_VAL;
                  end
                  W_IDLE: begin
                     pbus_out_q <= IDLE_VAL;
                  end
                  W_FPAL: begin
                     fpal_gnt_q <= bus.fpal_req;
                     pbus_out_q <= bus.fpal_req ? {4'h0, bus.fix_pal, 16'h0000}
                                                : EMPTY_VAL;
                  end
                  default: begin
                     pbus_out_q <= EMPTY_VAL;
                  end
               endcase
            end

            if (capture) begin
               l0_data_q  <= bus.pbus_in[7:0];
               l0_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.slot      = slot_q;
   assign bus.pbus_out  = pbus_out_q;
   assign bus.pbus_oe_u = oe_u_q;
   assign bus.pbus_oe_l = oe_l_q;
   assign bus.spr_gnt   = spr_gnt_q;
   assign bus.l0_gnt    = l0_gnt_q;
   assign bus.attr_gnt  = attr_gnt_q;
   assign bus.fix_gnt   = fix_gnt_q;
   assign bus.fpal_gnt  = fpal_gnt_q;
   assign bus.pck1      = pck1_q;
   assign bus.pck2      = pck2_q;
   assign bus.load      = load_q;
   assign bus.nvcs      = nvcs_q;
   assign bus.l0_data   = l0_data_q;
   assign bus.l0_valid  = l0_valid_q;

`ifdef PBUS_STALL_CNT_EN
   logic [15:0] stall_q;
   logic        stall_any;

   // A requester is stalled in any cycle its request is up but its grant
   // pulse is not showing.
   assign stall_any = (bus.spr_req  & ~spr_gnt_q)  |
                      (bus.l0_req   & ~l0_gnt_q)   |
                      (bus.attr_req & ~attr_gnt_q) |
                      (bus.fix_req  & ~fix_gnt_q)  |
                      (bus.fpal_req & ~fpal_gnt_q);

   always_ff @(posedge clk_24m or negedge nreset) begin
      if (!nreset) begin
         stall_q <= 16'h0000;
      end else if (bus.stall_clr) begin
         stall_q <= 16'h0000;
      end else if (stall_any && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'h0001;
      end
   end

   assign bus.stall_cnt = stall_q;
`endif

endmodule
